// File: rtl/barcode_frame_ctrl_if.sv
// Symbol/frame bus between the barcode decoder side, the frame consumer and barcode_frame_ctrl.
// The master drives En/Y/Ready. The slave (the controller) drives the decoder reset and the frame outputs.
interface barcode_frame_ctrl_if;
    logic       En;
    logic [1:0] Y;
    logic       Ready;
    logic       DecRst;
    logic [7:0] Data;
    logic [3:0] Len;
    logic       Valid;
    logic       Err;

    modport master (
        output En, Y, Ready,
        input  DecRst, Data, Len, Valid, Err
    );

    modport slave (
        input  En, Y, Ready,
        output DecRst, Data, Len, Valid, Err
    );
endinterface

// File: rtl/barcode_frame_ctrl.sv
// Assembles decoder bit symbols into frames and hands each frame over with a Valid/Ready handshake.
// Optional macro BARCODE_PARITY_CHECK_EN adds a trailing even-parity bit that is checked and stripped.
module barcode_frame_ctrl #(
    parameter int MAX_BITS   = 8,
    parameter int IDLE_LIMIT = 15
) (
    input  logic                 Clk,
    input  logic                 Rst,
    barcode_frame_ctrl_if.slave  bus
);

`ifdef BARCODE_PARITY_CHECK_EN
    localparam int SR_W = MAX_BITS + 1;
`else
    localparam int SR_W = MAX_BITS;
`endif
    localparam logic [3:0] CNT_LIMIT = 4'(SR_W);
    localparam logic [3:0] IDLE_MAX  = 4'(IDLE_LIMIT);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD, FLUSH} state_t;

    state_t          state_reg, state_next;
    logic [SR_W-1:0] shift_reg, shift_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [3:0]      idle_reg, idle_next, idle_inc;
    logic            dec_rst_reg, dec_rst_next;
    logic            valid_reg, valid_next;
    logic            err_reg, err_next;
    logic [7:0]      data_reg, data_next, frame_data;
    logic [3:0]      len_reg, len_next, frame_len;
    logic            bit_wr, clr_frame, load_frame, err_evt;

    assign idle_inc = (idle_reg == 4'hF) ? idle_reg : idle_reg + 4'd1;

`ifdef BARCODE_PARITY_CHECK_EN
    logic parity_bad;
    // Bits above cnt are always zero, so a full-width XOR covers payload plus parity.
    assign parity_bad = ^shift_reg;
    assign frame_len  = cnt_reg - 4'd1;
`else
    assign frame_len  = cnt_reg;
`endif

    // Shift register: bit symbols land at position cnt, first bit at index 0.
    generate
        for (genvar gi = 0; gi < SR_W; gi++) begin : g_shift
            assign shift_next[gi] = clr_frame ? 1'b0 :
                                    (bit_wr && cnt_reg == 4'(gi)) ? bus.Y[1] :
                                    shift_reg[gi];
        end

        for (genvar gi = 0; gi < 8; gi++) begin : g_frame
            if (gi < MAX_BITS) begin : g_used
`ifdef BARCODE_PARITY_CHECK_EN
                assign frame_data[gi] = shift_reg[gi] & (4'(gi) < frame_len);
`else
                assign frame_data[gi] = shift_reg[gi];
`endif
            end else begin : g_unused
                assign frame_data[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= 4'd0;
            idle_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            idle_reg  <= idle_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idle_next  = idle_reg;
        bit_wr     = 1'b0;
        clr_frame  = 1'b0;
        load_frame = 1'b0;
        err_evt    = 1'b0;
        case (state_reg)
            IDLE: begin
                clr_frame = 1'b1;
                cnt_next  = 4'd0;
                idle_next = 4'd0;
                if (bus.En) state_next = COLLECT;
            end
            COLLECT: begin
                if (!bus.En) begin
                    // Capture withdrawn: drop the partial frame without flagging it.
                    state_next = IDLE;
                    clr_frame  = 1'b1;
                    cnt_next   = 4'd0;
                    idle_next  = 4'd0;
                end else begin
                    case (bus.Y)
                        2'b01, 2'b10: begin
                            if (cnt_reg == CNT_LIMIT) begin
                                err_evt    = 1'b1;
                                state_next = FLUSH;
                            end else begin
                                bit_wr    = 1'b1;
                                cnt_next  = cnt_reg + 4'd1;
                                idle_next = 4'd0;
                            end
                        end
                        2'b00: begin
                            idle_next = idle_inc;
                            if (cnt_reg != 4'd0 && idle_inc == IDLE_MAX) begin
                                err_evt    = 1'b1;
                                state_next = FLUSH;
                            end
                        end
                        default: begin
                            if (cnt_reg != 4'd0) begin
`ifdef BARCODE_PARITY_CHECK_EN
                                if (cnt_reg == 4'd1) begin
                                    state_next = FLUSH;
                                end else if (parity_bad) begin
                                    err_evt    = 1'b1;
                                    state_next = FLUSH;
                                end else begin
                                    load_frame = 1'b1;
                                    state_next = HOLD;
                                end
`else
                                load_frame = 1'b1;
                                state_next = HOLD;
`endif
                            end
                        end
                    endcase
                end
            end
            HOLD: begin
                if (valid_reg && bus.Ready) state_next = FLUSH;
            end
            FLUSH: begin
                clr_frame  = 1'b1;
                cnt_next   = 4'd0;
                idle_next  = 4'd0;
                state_next = bus.En ? COLLECT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they track the state register exactly.
    always_comb begin
        dec_rst_next = (state_next != COLLECT);
        valid_next   = (state_next == HOLD);
        err_next     = err_evt;
        data_next    = load_frame ? frame_data : data_reg;
        len_next     = load_frame ? frame_len  : len_reg;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            dec_rst_reg <= 1'b1;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
            data_reg    <= 8'h00;
            len_reg     <= 4'd0;
        end else begin
            dec_rst_reg <= dec_rst_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
            data_reg    <= data_next;
            len_reg     <= len_next;
        end
    end

    assign bus.DecRst = dec_rst_reg;
    assign bus.Valid  = valid_reg;
    assign bus.Err    = err_reg;
    assign bus.Data   = data_reg;
    assign bus.Len    = len_reg;

endmodule

// File: tb/tb_barcode_frame_ctrl.sv
// Directed bench for barcode_frame_ctrl: a per-cycle vector table plus hand sequences for
// overflow, timeout, reset and (when BARCODE_PARITY_CHECK_EN is defined) parity.
module tb_barcode_frame_ctrl;

    logic Clk = 1'b0;
    logic Rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    barcode_frame_ctrl_if bus();

    barcode_frame_ctrl #(.MAX_BITS(8), .IDLE_LIMIT(15)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

`ifdef BARCODE_PARITY_CHECK_EN
    // Frame 0,1,[1] -> payload 0,1; frame 1 alone is only a parity bit and is discarded.
    localparam logic [7:0] D1 = 8'h02;
    localparam logic [3:0] L1 = 4'd2;
    localparam logic [7:0] D2 = 8'h02;
    localparam logic [3:0] L2 = 4'd2;
    localparam logic       V2 = 1'b0;
    localparam logic [7:0] HD = 8'h01;
    localparam logic [3:0] HL = 4'd1;
`else
    localparam logic [7:0] D1 = 8'h06;
    localparam logic [3:0] L1 = 4'd3;
    localparam logic [7:0] D2 = 8'h01;
    localparam logic [3:0] L2 = 4'd1;
    localparam logic       V2 = 1'b1;
    localparam logic [7:0] HD = 8'h03;
    localparam logic [3:0] HL = 4'd2;
`endif

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] y;
        logic       rdy;
        logic       dec;
        logic       val;
        logic       err;
        logic [7:0] data;
        logic [3:0] len;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic rst, input logic en, input logic [1:0] y,
                                input logic rdy, input logic dec, input logic val,
                                input logic err, input logic [7:0] data, input logic [3:0] len);
        vec_t v;
        v.rst = rst; v.en = en; v.y = y; v.rdy = rdy;
        v.dec = dec; v.val = val; v.err = err; v.data = data; v.len = len;
        return v;
    endfunction

    task automatic step(input logic rst, input logic en, input logic [1:0] y, input logic rdy);
        Rst       = rst;
        bus.En    = en;
        bus.Y     = y;
        bus.Ready = rdy;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic dec, input logic val, input logic err,
                         input logic [7:0] data, input logic [3:0] len);
        n_cmp++;
        $display("[%0t] %s: dec=%b val=%b err=%b data=%h len=%0d", $time, name,
                 bus.DecRst, bus.Valid, bus.Err, bus.Data, bus.Len);
        if ({bus.DecRst, bus.Valid, bus.Err, bus.Data, bus.Len} !== {dec, val, err, data, len}) begin
            n_bad++;
            $display("FAIL %s: got dec/val/err/data/len=%b/%b/%b/%h/%0d required %b/%b/%b/%h/%0d",
                     name, bus.DecRst, bus.Valid, bus.Err, bus.Data, bus.Len,
                     dec, val, err, data, len);
        end
    endtask

    initial begin
        Rst = 1'b0; bus.En = 1'b0; bus.Y = 2'b00; bus.Ready = 1'b0;

        //             rst   en    y      rdy   dec   val   err   data   len
        tbl[0]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        tbl[1]  = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        tbl[2]  = mk(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
        tbl[3]  = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
        tbl[4]  = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
        tbl[5]  = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
        tbl[6]  = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, D1,    L1);
        tbl[7]  = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, D1,    L1);
        tbl[8]  = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, D1,    L1);
        tbl[9]  = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, D1,    L1);
        tbl[10] = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, D1,    L1);
        tbl[11] = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, D1,    L1);
        tbl[12] = mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, D1,    L1);
        tbl[13] = mk(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, D1,    L1);
        tbl[14] = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, D1,    L1);
        tbl[15] = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, D1,    L1);
        tbl[16] = mk(1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, D1,    L1);
        tbl[17] = mk(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, D1,    L1);
        tbl[18] = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, D1,    L1);
        tbl[19] = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, V2,   1'b0, D2,    L2);
        tbl[20] = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, D2,    L2);
        tbl[21] = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, D2,    L2);
        tbl[22] = mk(1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, D2,    L2);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].y, tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].dec, tbl[i].val, tbl[i].err,
                  tbl[i].data, tbl[i].len);
        end

`ifndef BARCODE_PARITY_CHECK_EN
        // Overflow: nine bit symbols with MAX_BITS=8.
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("ovf_enter", 1'b0, 1'b0, 1'b0, D2, L2);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 2'd2, 1'b0);
            check($sformatf("ovf_bit%0d", i), 1'b0, 1'b0, 1'b0, D2, L2);
        end
        step(1'b1, 1'b1, 2'd2, 1'b0);
        check("ovf_err", 1'b1, 1'b0, 1'b1, D2, L2);
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("ovf_recover", 1'b0, 1'b0, 1'b0, D2, L2);
`else
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("collect_enter", 1'b0, 1'b0, 1'b0, D2, L2);
`endif

        // Timeout: one bit then 15 dashes; afterwards 20 dashes with an empty frame.
        step(1'b1, 1'b1, 2'd1, 1'b0);
        check("to_bit", 1'b0, 1'b0, 1'b0, D2, L2);
        for (int i = 1; i < 15; i++) begin
            step(1'b1, 1'b1, 2'd0, 1'b0);
            check($sformatf("to_dash%0d", i), 1'b0, 1'b0, 1'b0, D2, L2);
        end
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("to_err", 1'b1, 1'b0, 1'b1, D2, L2);
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("to_recover", 1'b0, 1'b0, 1'b0, D2, L2);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 2'd0, 1'b0);
            check($sformatf("empty_dash%0d", i), 1'b0, 1'b0, 1'b0, D2, L2);
        end

        // Reset with four bits collected.
        step(1'b1, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b0);
        step(1'b1, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b1, 2'd2, 1'b0);
        check("mid_cnt4", 1'b0, 1'b0, 1'b0, D2, L2);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        check("mid_rst", 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check("mid_idle", 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);

        // Reset while holding a frame, Ready never asserted.
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("hold_collect", 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
        step(1'b1, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b1, 2'd3, 1'b0);
        check("hold_frame", 1'b1, 1'b1, 1'b0, HD, HL);
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("hold_wait", 1'b1, 1'b1, 1'b0, HD, HL);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        check("hold_rst", 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("hold_after", 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);

`ifdef BARCODE_PARITY_CHECK_EN
        // Good parity: 1,1,[0] -> Data=0x03, Len=2.
        step(1'b1, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b0);
        check("par_bits", 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
        step(1'b1, 1'b1, 2'd3, 1'b0);
        check("par_ok", 1'b1, 1'b1, 1'b0, 8'h03, 4'd2);
        step(1'b1, 1'b1, 2'd0, 1'b1);
        check("par_flush", 1'b1, 1'b0, 1'b0, 8'h03, 4'd2);
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("par_collect", 1'b0, 1'b0, 1'b0, 8'h03, 4'd2);
        // Bad parity: 1,0,[0].
        step(1'b1, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b0);
        step(1'b1, 1'b1, 2'd3, 1'b0);
        check("par_bad", 1'b1, 1'b0, 1'b1, 8'h03, 4'd2);
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("par_bad_next", 1'b0, 1'b0, 1'b0, 8'h03, 4'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/barcode_frame_ctrl.md
BARCODE_FRAME_CTRL -- requirements
Module: barcode_frame_ctrl

Interface
REQ-001 Parameter MAX_BITS, default 8: maximum payload bits per frame (1..8).
REQ-002 Parameter IDLE_LIMIT, default 15: consecutive dash symbols tolerated inside a non-empty frame (1..15).
REQ-003 Clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Rst  input  1  synchronous, active-low reset: sampled only on rising Clk, 0 = reset.
REQ-005 En  input  1  capture enable; 1 = accept decoder symbols.
REQ-006 Y  input  2  decoder symbol: 00 dash, 01 bit 0, 10 bit 1, 11 end.
REQ-007 DecRst  output  1  active-high reset to the barcode decoder.
REQ-008 Data  output  8  assembled frame, first received bit at Data[0]; unused bits 0.
REQ-009 Len  output  4  payload bit count, 0..MAX_BITS.
REQ-010 Valid  output  1  frame available.
REQ-011 Ready  input  1  consumer accepts frame when Valid=1.
REQ-012 Err  output  1  one-cycle error pulse.

Function
REQ-013 FSM states SHALL be IDLE, COLLECT, HOLD, FLUSH; all outputs registered.
REQ-014 IDLE: DecRst=1; En=1 -> COLLECT; else stay.
REQ-015 COLLECT: DecRst=0; each cycle samples Y once.
- Y=01/10: bit written at shift_reg[cnt], cnt+1, idle counter cleared.
- Y=00: idle counter +1 (saturating).
- Y=11 with cnt>0: Data/Len loaded, Valid=1 at that edge, -> HOLD.
- Y=11 with cnt=0: ignored, stay COLLECT, no Err.
REQ-016 Overflow: bit symbol with cnt==MAX_BITS -> Err=1 for one cycle, frame discarded, -> FLUSH.
REQ-017 Timeout: idle counter reaching IDLE_LIMIT with cnt>0 -> Err=1 for one cycle, -> FLUSH; with cnt=0 dashes never time out.
REQ-018 En=0 in COLLECT -> IDLE, partial frame discarded silently, no Err; En ignored in HOLD and FLUSH.
REQ-019 HOLD: Valid=1, Data/Len stable, DecRst=1, Y ignored; Valid&Ready at an edge -> Valid=0, -> FLUSH.
REQ-020 FLUSH: exactly one cycle, DecRst=1, shift_reg/cnt/idle counter cleared; -> COLLECT if En=1, else IDLE.
REQ-021 Valid and Err SHALL never be 1 in the same cycle.
REQ-022 Data and Len SHALL hold the last delivered frame until the next Valid load.

Reset
REQ-023 Rst=0 at a rising edge: state IDLE, DecRst=1, Valid=0, Err=0, Data=0, Len=0, counters 0; overrides every other input.
REQ-024 Rst=0 during HOLD SHALL drop Valid without requiring Ready; the frame is lost.

Configuration
REQ-025 Macro BARCODE_PARITY_CHECK_EN defined: last bit before END is an even-parity bit over the preceding bits; it is not stored in Data nor counted in Len; the cnt limit becomes MAX_BITS+1; a mismatch SHALL give Err=1 and FLUSH with no Valid; a frame holding only the parity bit SHALL be discarded silently.
REQ-026 Macro undefined: every bit is payload, no parity logic synthesised, Err sources are overflow and timeout only.

Verification
REQ-027 Reset then En=1, Y=01,10,10,11 -> Valid=1, Data=0x06, Len=3, DecRst=1 while in HOLD.
REQ-028 Valid=1 with Ready=0 for 5 cycles, then Ready=1 -> Data stable throughout, Valid=0 next cycle, DecRst=1 for one FLUSH cycle, then COLLECT.
REQ-029 Nine bit symbols with MAX_BITS=8 (parity off) -> Err pulse on the ninth, no Valid, Len unchanged.
REQ-030 One bit then 15 dashes -> Err pulse on the fifteenth dash; 20 dashes with cnt=0 -> no Err.
REQ-031 Rst=0 mid-frame (cnt=4) and during HOLD -> next cycle IDLE, Valid=0, Len=0, DecRst=1.
REQ-032 Parity on: Y=10,10,01,11 -> Valid, Data=0x03, Len=2; Y=10,01,01,11 -> Err pulse, no Valid.
